// File: rtl/dist_calc_pkg.sv
// Shared distance-calc definitions: loader state encoding, BRAM flag bit positions
// and the element-index width helper.
package dist_calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    localparam int unsigned FLAG_W   = 4;
    localparam int unsigned FLAG_CS  = 3;
    localparam int unsigned FLAG_WE  = 2;
    localparam int unsigned FLAG_OE  = 1;
    localparam int unsigned FLAG_SEL = 0;

    // Index width that stays at least one bit, so single-element vectors still have an address.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_elem_counter.sv
// Element counter for the loader: counts 0..VECWIDTH-1, wraps and toggles the vector select.
module vec_elem_counter
    import dist_calc_pkg::*;
#(
    parameter int unsigned VECWIDTH = 10,
    parameter int unsigned AW       = idx_width(VECWIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] cnt,
    output logic          vecsel,
    output logic          last_c
);

    logic [AW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          wrap_c;

    assign wrap_c = (cnt_q == AW'(VECWIDTH - 1));
    assign cnt    = cnt_q;
    assign vecsel = sel_q;
    assign last_c = wrap_c & sel_q;

    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (clear) begin
            cnt_d = '0;
            sel_d = 1'b0;
        end else if (inc) begin
            if (wrap_c) begin
                cnt_d = '0;
                sel_d = ~sel_q;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/vec_bram_loader.sv
// Streams two VECWIDTH-element vectors into BRAM, one registered write per accepted
// element, then pulses DONE/STARTCALC to kick off the distance calculation.
module vec_bram_loader
    import dist_calc_pkg::*;
#(
    parameter int unsigned VARWIDTH = 32,
    parameter int unsigned VECWIDTH = 10
) (
    input  logic                               clk,
    input  logic                               RST_N,
    input  logic                               LOAD,
    input  logic                               ABORT,
    input  logic                               IN_VALID,
    input  logic [VARWIDTH-1:0]                IN_DATA,
    output logic                               IN_READY,
    output logic [idx_width(VECWIDTH)-1:0]     ADDR_Bram,
    output logic [VARWIDTH-1:0]                DATA_Bram,
    output logic [3:0]                         FLAG_Bram,
    output logic                               BUSY,
    output logic                               DONE,
    output logic                               STARTCALC
);

    localparam int unsigned AW = idx_width(VECWIDTH);

    ld_state_e               state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [VARWIDTH-1:0]     data_q, data_d;
    logic [FLAG_W-1:0]       flag_q, flag_d;

    logic [AW-1:0]           cnt;
    logic                    vecsel;
    logic                    last_c;
    logic                    cnt_clear_c;
    logic                    cnt_inc_c;

    vec_elem_counter #(
        .VECWIDTH (VECWIDTH),
        .AW       (AW)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (RST_N),
        .clear  (cnt_clear_c),
        .inc    (cnt_inc_c),
        .cnt    (cnt),
        .vecsel (vecsel),
        .last_c (last_c)
    );

    // Status outputs decode the state register directly.
    assign IN_READY  = (state_q == ST_FILL);
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_DONE);
    assign STARTCALC = (state_q == ST_DONE);
    assign ADDR_Bram = addr_q;
    assign DATA_Bram = data_q;
    assign FLAG_Bram = flag_q;

    // Next state and BRAM write request; an ABORT on the handshake edge drops the write.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        flag_d           = flag_q;
        flag_d[FLAG_CS]  = 1'b0;
        flag_d[FLAG_WE]  = 1'b0;
        flag_d[FLAG_OE]  = 1'b0;
        cnt_clear_c      = 1'b0;
        cnt_inc_c        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (LOAD && !ABORT) begin
                    state_d     = ST_FILL;
                    cnt_clear_c = 1'b1;
                end
            end
            ST_FILL: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (IN_VALID) begin
                    cnt_inc_c        = 1'b1;
                    addr_d           = cnt;
                    data_d           = IN_DATA;
                    flag_d[FLAG_CS]  = 1'b1;
                    flag_d[FLAG_WE]  = 1'b1;
                    flag_d[FLAG_SEL] = vecsel;
                    if (last_c) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ABORT ? ST_IDLE : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
        end
    end

endmodule

// File: tb/tb_vec_bram_loader.sv
// Self-checking bench for vec_bram_loader: per-cycle comparison against an element-index
// model, plus directed scenarios with literal expectations (second instance uses VECWIDTH=1).
module tb_vec_bram_loader;

    localparam int unsigned VW = 10;

    logic        clk;
    logic        RST_N;
    logic        LOAD, ABORT, IN_VALID;
    logic [31:0] IN_DATA;
    logic        IN_READY;
    logic [3:0]  ADDR_Bram;
    logic [31:0] DATA_Bram;
    logic [3:0]  FLAG_Bram;
    logic        BUSY, DONE, STARTCALC;

    logic        l1_load, l1_abort, l1_valid;
    logic [31:0] l1_data;
    logic        l1_ready;
    logic [0:0]  l1_addr;
    logic [31:0] l1_dout;
    logic [3:0]  l1_flag;
    logic        l1_busy, l1_done, l1_start;

    vec_bram_loader #(.VARWIDTH(32), .VECWIDTH(VW)) dut (
        .clk(clk), .RST_N(RST_N), .LOAD(LOAD), .ABORT(ABORT), .IN_VALID(IN_VALID),
        .IN_DATA(IN_DATA), .IN_READY(IN_READY), .ADDR_Bram(ADDR_Bram), .DATA_Bram(DATA_Bram),
        .FLAG_Bram(FLAG_Bram), .BUSY(BUSY), .DONE(DONE), .STARTCALC(STARTCALC)
    );

    vec_bram_loader #(.VARWIDTH(32), .VECWIDTH(1)) dut1 (
        .clk(clk), .RST_N(RST_N), .LOAD(l1_load), .ABORT(l1_abort), .IN_VALID(l1_valid),
        .IN_DATA(l1_data), .IN_READY(l1_ready), .ADDR_Bram(l1_addr), .DATA_Bram(l1_dout),
        .FLAG_Bram(l1_flag), .BUSY(l1_busy), .DONE(l1_done), .STARTCALC(l1_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: phase 0 idle, 1 accepting, 2 final write showing, 3 done; n = elements accepted.
    int          m_phase = 0;
    int          m_n     = 0;
    logic        m_wr    = 1'b0;
    logic [3:0]  m_addr  = '0;
    logic        m_sel   = 1'b0;
    logic [31:0] m_data  = '0;

    always @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            m_phase <= 0;
            m_n     <= 0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_sel   <= 1'b0;
            m_data  <= '0;
        end else begin
            m_wr <= 1'b0;
            case (m_phase)
                0: if (LOAD && !ABORT) begin
                    m_phase <= 1;
                    m_n     <= 0;
                end
                1: if (ABORT) begin
                    m_phase <= 0;
                end else if (IN_VALID) begin
                    m_wr   <= 1'b1;
                    m_addr <= 4'(m_n % VW);
                    m_sel  <= (m_n / VW) != 0;
                    m_data <= IN_DATA;
                    m_n    <= m_n + 1;
                    if (m_n + 1 == 2 * VW) m_phase <= 2;
                end
                2: m_phase <= ABORT ? 0 : 3;
                default: m_phase <= 0;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    int          lg_n = 0;
    logic [3:0]  lg_addr [0:255];
    logic        lg_sel  [0:255];
    logic [31:0] lg_data [0:255];
    int          lg_cyc  [0:255];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          hs_cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    task automatic chk_entry(input int i, input int a, input int s, input int d);
        chk($sformatf("write_%0d", i),
            64'({lg_addr[i], lg_sel[i], lg_data[i]}),
            64'({4'(a), 1'(s), 32'(d)}));
    endtask

    task automatic compare_and_log();
        chk("in_ready",  64'(IN_READY),  64'(m_phase == 1));
        chk("busy",      64'(BUSY),      64'(m_phase != 0));
        chk("done",      64'(DONE),      64'(m_phase == 3));
        chk("startcalc", 64'(STARTCALC), 64'(m_phase == 3));
        chk("flag",      64'(FLAG_Bram), 64'({m_wr, m_wr, 1'b0, m_sel}));
        chk("addr",      64'(ADDR_Bram), 64'(m_addr));
        chk("data",      64'(DATA_Bram), 64'(m_data));
        if (FLAG_Bram[3] && FLAG_Bram[2] && lg_n < 256) begin
            lg_addr[lg_n] = ADDR_Bram;
            lg_sel[lg_n]  = FLAG_Bram[0];
            lg_data[lg_n] = DATA_Bram;
            lg_cyc[lg_n]  = ncyc;
            lg_n++;
        end
        if (IN_VALID && IN_READY) hs_cyc = ncyc;
        if (DONE) begin
            done_cnt++;
            done_cyc = ncyc;
        end
    endtask

    // One clock: compare on the falling edge, return 2 time units after the rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_and_log();
        @(posedge clk);
        ncyc++;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic start_load();
        LOAD = 1'b1;
        cyc();
        LOAD = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle, input int abort_at, input int base,
                        input int load_at, output int got);
        int  t;
        bit  ph;
        bit  hs;
        bit  stop;
        t = 0; ph = 1'b0; stop = 1'b0; got = 0;
        while (got < n && t < 300 && !stop) begin
            IN_VALID = toggle ? ph : 1'b1;
            ph       = ~ph;
            IN_DATA  = 32'(base + got + 1);
            ABORT    = (abort_at != 0) && (got + 1 == abort_at) && IN_VALID;
            LOAD     = (load_at != 0) && (t == load_at);
            hs       = IN_VALID && IN_READY;
            cyc();
            t++;
            if (hs) got++;
            if (ABORT) stop = 1'b1;
        end
        IN_VALID = 1'b0;
        ABORT    = 1'b0;
        LOAD     = 1'b0;
        if (t >= 300) chk("feed_timeout", 64'(got), 64'(n));
    endtask

    initial begin
        int mark, dmark, got;
        RST_N = 1'b0; LOAD = 1'b0; ABORT = 1'b0; IN_VALID = 1'b0; IN_DATA = '0;
        l1_load = 1'b0; l1_abort = 1'b0; l1_valid = 1'b0; l1_data = '0;
        idle(2);
        chk("rst_outs", 64'({IN_READY, ADDR_Bram, DATA_Bram, FLAG_Bram, BUSY, DONE, STARTCALC}), 64'(0));
        chk("rst_outs1", 64'({l1_ready, l1_addr, l1_dout, l1_flag, l1_busy, l1_done, l1_start}), 64'(0));
        RST_N = 1'b1;
        idle(2);

        // Continuous stream of 1..20.
        mark = lg_n; dmark = done_cnt;
        start_load();
        feed(20, 1'b0, 0, 0, 0, got);
        idle(5);
        chk("s1_nwrites", 64'(lg_n - mark), 64'(20));
        chk_entry(mark,      0, 0, 1);
        chk_entry(mark + 9,  9, 0, 10);
        chk_entry(mark + 10, 0, 1, 11);
        chk_entry(mark + 19, 9, 1, 20);
        chk("s1_back_to_back", 64'(lg_cyc[mark + 19] - lg_cyc[mark]), 64'(19));
        chk("s1_ndone", 64'(done_cnt - dmark), 64'(1));
        chk("s1_done_latency", 64'(done_cyc - hs_cyc), 64'(2));

        // IN_VALID every other cycle.
        mark = lg_n; dmark = done_cnt;
        start_load();
        feed(20, 1'b1, 0, 100, 0, got);
        idle(4);
        chk("s2_nwrites", 64'(lg_n - mark), 64'(20));
        for (int i = 0; i < 20; i++) chk_entry(mark + i, i % 10, i / 10, 101 + i);
        chk("s2_ndone", 64'(done_cnt - dmark), 64'(1));

        // Abort on the 7th handshake.
        mark = lg_n; dmark = done_cnt;
        start_load();
        feed(20, 1'b0, 7, 200, 0, got);
        chk("s3_busy_after_abort", 64'(BUSY), 64'(0));
        idle(4);
        chk("s3_nwrites", 64'(lg_n - mark), 64'(6));
        chk_entry(mark + 5, 5, 0, 206);
        chk("s3_ndone", 64'(done_cnt - dmark), 64'(0));
        mark = lg_n;
        start_load();
        feed(1, 1'b0, 0, 300, 0, got);
        feed(4, 1'b0, 0, 301, 0, got);
        chk_entry(mark, 0, 0, 301);

        // Half-cycle reset in the middle of a fill.
        RST_N = 1'b0;
        #1;
        chk("s4_rst_outs", 64'({IN_READY, ADDR_Bram, DATA_Bram, FLAG_Bram, BUSY, DONE, STARTCALC}), 64'(0));
        #4;
        RST_N = 1'b1;
        mark = lg_n;
        IN_VALID = 1'b1;
        idle(4);
        chk("s4_no_write_after_rst", 64'(lg_n - mark), 64'(0));
        chk("s4_not_ready", 64'(IN_READY), 64'(0));
        IN_VALID = 1'b0;
        mark = lg_n; dmark = done_cnt;
        start_load();
        feed(20, 1'b0, 0, 400, 0, got);
        idle(4);
        chk("s4_nwrites", 64'(lg_n - mark), 64'(20));
        chk_entry(mark, 0, 0, 401);
        chk("s4_ndone", 64'(done_cnt - dmark), 64'(1));

        // LOAD during FILL and during DONE is ignored.
        mark = lg_n; dmark = done_cnt;
        start_load();
        feed(20, 1'b0, 0, 500, 3, got);
        cyc();
        chk("s5_in_done", 64'(DONE), 64'(1));
        LOAD = 1'b1;
        cyc();
        LOAD = 1'b0;
        idle(3);
        chk("s5_idle", 64'(BUSY), 64'(0));
        chk("s5_nwrites", 64'(lg_n - mark), 64'(20));
        chk_entry(mark + 3,  3, 0, 504);
        chk_entry(mark + 13, 3, 1, 514);
        chk("s5_ndone", 64'(done_cnt - dmark), 64'(1));

        // VECWIDTH=1 instance: two writes, FLUSH, DONE, IDLE.
        l1_load = 1'b1;
        cyc();
        l1_load = 1'b0;
        chk("v1_fill", 64'({l1_ready, l1_busy, l1_flag}), 64'({1'b1, 1'b1, 4'b0000}));
        l1_valid = 1'b1; l1_data = 32'd7;
        cyc();
        chk("v1_wr0", 64'({l1_ready, l1_flag, l1_addr, l1_dout}), 64'({1'b1, 4'b1100, 1'b0, 32'd7}));
        l1_data = 32'd8;
        cyc();
        l1_valid = 1'b0;
        chk("v1_wr1", 64'({l1_ready, l1_busy, l1_done, l1_flag, l1_addr, l1_dout}),
            64'({1'b0, 1'b1, 1'b0, 4'b1101, 1'b0, 32'd8}));
        cyc();
        chk("v1_done", 64'({l1_done, l1_start, l1_busy, l1_flag}), 64'({1'b1, 1'b1, 1'b1, 4'b0001}));
        cyc();
        chk("v1_idle", 64'({l1_done, l1_start, l1_busy, l1_ready}), 64'(0));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_bram_loader.md
VEC_BRAM_LOADER -- requirements
Module: vec_bram_loader

Interface
REQ-001 SHALL have parameter VARWIDTH, default 32, meaning bit width of one vector element.
REQ-002 SHALL have parameter VECWIDTH, default 10, meaning elements per vector.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port LOAD, input, 1, one-cycle request to begin loading two vectors.
REQ-006 SHALL have port ABORT, input, 1, synchronous cancel of a load in progress.
REQ-007 SHALL have port IN_VALID, input, 1, element present on IN_DATA.
REQ-008 SHALL have port IN_DATA, input, VARWIDTH, element value.
REQ-009 SHALL have port IN_READY, output, 1, loader accepts an element this cycle.
REQ-010 SHALL have port ADDR_Bram, output, $clog2(VECWIDTH), element index within the selected vector.
REQ-011 SHALL have port DATA_Bram, output, VARWIDTH, write data to BRAM.
REQ-012 SHALL have port FLAG_Bram, output, 4, bits {cs, we, oe, vecsel} (bit3..bit0).
REQ-013 SHALL have port BUSY, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port DONE, output, 1, one-cycle pulse when both vectors are written.
REQ-015 SHALL have port STARTCALC, output, 1, one-cycle pulse, coincident with DONE, to start the distance control unit.

Function
REQ-016 SHALL implement states IDLE, FILL, FLUSH, DONE.
REQ-017 IDLE: LOAD=1 SHALL move to FILL and clear element counter and vecsel to 0; LOAD in any other state SHALL be ignored.
REQ-018 IN_READY SHALL equal (state==FILL), combinationally from the state register only.
REQ-019 A handshake (IN_VALID & IN_READY at a rising edge) SHALL register ADDR_Bram=counter, DATA_Bram=IN_DATA, FLAG_Bram={1,1,0,vecsel}, so the BRAM write is presented in the following cycle.
REQ-020 In any cycle without a registered write, FLAG_Bram[3:1] SHALL be 000; ADDR_Bram, DATA_Bram and FLAG_Bram[0] SHALL hold their last values.
REQ-021 After each handshake the counter SHALL increment; at VECWIDTH-1 it SHALL wrap to 0 and vecsel SHALL toggle 0->1.
REQ-022 The handshake with counter=VECWIDTH-1 and vecsel=1 SHALL move FILL->FLUSH (the final write is presented in the FLUSH cycle).
REQ-023 FLUSH SHALL last exactly one cycle, then enter DONE; DONE SHALL last exactly one cycle, then enter IDLE.
REQ-024 DONE and STARTCALC SHALL be 1 only while in state DONE.
REQ-025 IN_VALID low in FILL SHALL stall with no write and no counter change; there SHALL be no timeout.
REQ-026 ABORT=1 in FILL or FLUSH SHALL return to IDLE on that edge; no DONE/STARTCALC is issued; a write registered on the same edge SHALL be suppressed (FLAG_Bram[3:1]=000).
REQ-027 ABORT in IDLE or DONE SHALL have no effect; ABORT and LOAD together in IDLE SHALL give ABORT priority (stay IDLE).
REQ-028 FLAG_Bram[1] (oe) SHALL never be driven 1 by this block.

Reset
REQ-029 RST_N=0 SHALL asynchronously force state IDLE, counter 0, vecsel 0, ADDR_Bram 0, DATA_Bram 0, FLAG_Bram 0000, DONE 0, STARTCALC 0, BUSY 0, IN_READY 0.
REQ-030 Reset asserted mid-load SHALL discard all progress; the next LOAD SHALL restart at element 0 of vector 0.

Structure
REQ-031 State encodings and the FLAG_Bram bit positions (CS=3, WE=2, OE=1, SEL=0) SHALL live in the shared distance-calc package, also used by dist_control_unit.
REQ-032 The element counter with wrap and vecsel toggle SHALL be one sub-module, vec_elem_counter; no other sub-module.

Verification
REQ-033 Defaults, LOAD, IN_VALID held high with data 1..20 -> writes addr 0..9 sel 0 (data 1..10) then addr 0..9 sel 1 (data 11..20) on consecutive cycles; DONE and STARTCALC high exactly 2 cycles after the last handshake.
REQ-034 IN_VALID toggled every other cycle -> exactly 20 writes, no duplicate or skipped address, IN_READY high throughout FILL.
REQ-035 ABORT on the 7th handshake -> 6 writes only, no DONE, BUSY low next cycle; a new LOAD then writes addr 0 sel 0 first.
REQ-036 RST_N low for half a cycle mid-FILL -> all outputs 0 immediately; no write after release until LOAD.
REQ-037 LOAD pulsed during FILL and during DONE -> ignored; counter and vecsel unchanged; exactly one DONE pulse.
REQ-038 VECWIDTH=1 -> two writes (addr 0 sel 0, addr 0 sel 1), then FLUSH, DONE, IDLE.
